calc_seq_ctrl: RTL and testbench

- Operation sequencer for the calculator datapath: interprets one-cycle push-button event pulses and drives the operand entry shifter, register-file writes, operand selects, ALU start/done handshake and display select.
- Sits between the button synchronizer/edge-detector and the entry register / register file / ALU / seven-segment display path; also drives the red (error) and blue (busy) LEDs.

---
 rtl/calc_pkg.sv | 49 ++++
 rtl/calc_seq_ctrl_if.sv | 33 +++
 rtl/calc_pb_decode.sv | 39 +++
 rtl/calc_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_calc_seq_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator operation sequencer.
package calc_pkg;

  localparam int ENTRY_W_DEF = 8;
  localparam int NREG_DEF    = 4;
  localparam int PB_W        = 10;

  localparam int PB_BIT0  = 0;
  localparam int PB_BIT1  = 1;
  localparam int PB_WMODE = 2;
  localparam int PB_RMODE = 3;
  localparam int PB_ADD   = 4;
  localparam int PB_SUB   = 5;
  localparam int PB_REG0  = 6;
  localparam int PB_REG1  = 7;
  localparam int PB_REG2  = 8;
  localparam int PB_REG3  = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RSEL_A,
    ST_RSEL_B,
    ST_RSEL_OP,
    ST_EXEC,
    ST_SHOW
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01
  } alu_op_t;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_WRITE = 2'b01,
    MODE_READ  = 2'b10
  } mode_t;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_BIT,
    EV_WMODE,
    EV_RMODE,
    EV_OP,
    EV_REG
  } pb_ev_t;

endpackage

// File: rtl/calc_seq_ctrl_if.sv
// Button/ALU handshake and datapath control bundle of the sequencer.
interface calc_seq_ctrl_if #(
    parameter int ENTRY_W = 8,
    parameter int NREG    = 4
);
    logic [9:0]         pb_pulse;
    logic               alu_done;
    logic [ENTRY_W-1:0] entry_q;
    logic [NREG-1:0]    wr_en;
    logic [ENTRY_W-1:0] wr_data;
    logic [1:0]         src_a;
    logic [1:0]         src_b;
    logic [1:0]         alu_op;
    logic               alu_start;
    logic               disp_sel;
    logic [1:0]         mode;
    logic               red;
    logic               blue;

    // master: the sequencer itself
    modport master (
        input  pb_pulse, alu_done,
        output entry_q, wr_en, wr_data, src_a, src_b, alu_op,
               alu_start, disp_sel, mode, red, blue
    );

    // slave: buttons, register file, ALU and display
    modport slave (
        output pb_pulse, alu_done,
        input  entry_q, wr_en, wr_data, src_a, src_b, alu_op,
               alu_start, disp_sel, mode, red, blue
    );
endinterface

// File: rtl/calc_pb_decode.sv
// Classifies a push-button pulse vector into one event, with register index and multi-press flag.
module calc_pb_decode
  import calc_pkg::*;
(
    input  logic [PB_W-1:0] pb_pulse_i,
    output pb_ev_t          ev_o,
    output logic            bit_o,
    output alu_op_t         op_o,
    output logic [1:0]      reg_idx_o,
    output logic            multi_o
);

    int unsigned ones;

    always_comb begin
        ones = 0;
        for (int unsigned i = 0; i < PB_W; i++) begin
            ones = ones + 32'(pb_pulse_i[i]);
        end
        multi_o = (ones > 1);

        ev_o      = EV_NONE;
        bit_o     = pb_pulse_i[PB_BIT1];
        op_o      = pb_pulse_i[PB_SUB] ? ALU_SUB : ALU_ADD;
        reg_idx_o = 2'd0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (pb_pulse_i[PB_REG0 + k]) reg_idx_o = 2'(k);
        end

        if (ones == 1) begin
            if (pb_pulse_i[PB_BIT0] || pb_pulse_i[PB_BIT1]) ev_o = EV_BIT;
            else if (pb_pulse_i[PB_WMODE])                ev_o = EV_WMODE;
            else if (pb_pulse_i[PB_RMODE])                ev_o = EV_RMODE;
            else if (pb_pulse_i[PB_ADD] || pb_pulse_i[PB_SUB]) ev_o = EV_OP;
            else                                          ev_o = EV_REG;
        end
    end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator operation sequencer: operand entry, register writes, ALU launch/timeout and status LEDs.
module calc_seq_ctrl
  import calc_pkg::*;
#(
    parameter int ENTRY_W     = ENTRY_W_DEF,
    parameter int NREG        = NREG_DEF,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic         clk,
    input  logic         rst,
    calc_seq_ctrl_if.master bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    pb_ev_t     ev;
    logic       ev_bit;
    alu_op_t    ev_op;
    logic [1:0] ev_reg;
    logic       ev_multi;

    calc_pb_decode u_decode (
        .pb_pulse_i (bus.pb_pulse),
        .ev_o       (ev),
        .bit_o      (ev_bit),
        .op_o       (ev_op),
        .reg_idx_o  (ev_reg),
        .multi_o    (ev_multi)
    );

    state_t             state_q;
    logic [ENTRY_W-1:0] ent_q;
    logic [ENTRY_W-1:0] ent_d;
    logic               clr_pend_q;
    logic [NREG-1:0]    wr_en_q;
    logic [1:0]         src_a_q;
    logic [1:0]         src_b_q;
    alu_op_t            alu_op_q;
    logic               alu_start_q;
    logic               disp_sel_q;
    mode_t              mode_q;
    logic               red_q;
    logic               blue_q;
    logic [CNT_W-1:0]   cnt_q;

    // Shift source: a register write leaves entry pending-clear for one cycle so wr_data stays valid.
    always_comb begin
        ent_d = clr_pend_q ? '0 : ent_q;
        ent_d = {ent_d[ENTRY_W-2:0], ev_bit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ent_q       <= '0;
            clr_pend_q  <= 1'b0;
            wr_en_q     <= '0;
            src_a_q     <= '0;
            src_b_q     <= '0;
            alu_op_q    <= ALU_ADD;
            alu_start_q <= 1'b0;
            disp_sel_q  <= 1'b0;
            mode_q      <= MODE_IDLE;
            red_q       <= 1'b0;
            blue_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            wr_en_q     <= '0;
            alu_start_q <= 1'b0;
            clr_pend_q  <= 1'b0;
            if (clr_pend_q) ent_q <= '0;

            if (state_q == ST_EXEC) begin
                if (bus.alu_done) begin
                    blue_q     <= 1'b0;
                    disp_sel_q <= 1'b1;
                    state_q    <= ST_SHOW;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    blue_q     <= 1'b0;
                    red_q      <= 1'b1;
                    disp_sel_q <= 1'b0;
                    state_q    <= ST_SHOW;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (!ev_multi) begin
                if (ev == EV_WMODE || ev == EV_RMODE) begin
                    ent_q      <= '0;
                    red_q      <= 1'b0;
                    disp_sel_q <= 1'b0;
                    state_q    <= (ev == EV_WMODE) ? ST_WRITE : ST_RSEL_A;
                    mode_q     <= (ev == EV_WMODE) ? MODE_WRITE : MODE_READ;
                end else begin
                    case (state_q)
                        ST_WRITE: begin
                            if (ev == EV_BIT) begin
                                ent_q <= ent_d;
                            end else if (ev == EV_REG) begin
                                wr_en_q[ev_reg] <= 1'b1;
                                clr_pend_q      <= 1'b1;
                            end
                        end
                        ST_RSEL_A: begin
                            if (ev == EV_REG) begin
                                src_a_q <= ev_reg;
                                state_q <= ST_RSEL_B;
                            end else if (ev == EV_OP) begin
                                red_q <= 1'b1;
                            end
                        end
                        ST_RSEL_B: begin
                            if (ev == EV_REG) begin
                                src_b_q <= ev_reg;
                                state_q <= ST_RSEL_OP;
                            end else if (ev == EV_OP) begin
                                red_q <= 1'b1;
                            end
                        end
                        ST_RSEL_OP, ST_SHOW: begin
                            if (ev == EV_REG && state_q == ST_RSEL_OP) begin
                                src_b_q <= ev_reg;
                            end else if (ev == EV_OP) begin
                                alu_op_q    <= ev_op;
                                alu_start_q <= 1'b1;
                                blue_q      <= 1'b1;
                                cnt_q       <= '0;
                                state_q     <= ST_EXEC;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.entry_q   = ent_q;
    assign bus.wr_data   = ent_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.src_a     = src_a_q;
    assign bus.src_b     = src_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_start = alu_start_q;
    assign bus.disp_sel  = disp_sel_q;
    assign bus.mode      = mode_q;
    assign bus.red       = red_q;
    assign bus.blue      = blue_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed vector bench for calc_seq_ctrl: table of button/ALU stimulus plus timeout and reset sequences.
module tb_calc_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    calc_seq_ctrl_if #(.ENTRY_W(8), .NREG(4)) bus ();

    calc_seq_ctrl #(.ENTRY_W(8), .NREG(4), .TIMEOUT_CYC(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {entry, wr_en, src_a, src_b, alu_op, alu_start, disp_sel, mode, red, blue}
    typedef struct {
        logic [9:0]  pb;
        logic        done;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [23:0] pk(input logic [7:0] e, input logic [3:0] wr,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] op, input logic st, input logic dp,
                                       input logic [1:0] md, input logic rd, input logic bl);
        return {e, wr, sa, sb, op, st, dp, md, rd, bl};
    endfunction

    function automatic logic [23:0] obs();
        return {bus.entry_q, bus.wr_en, bus.src_a, bus.src_b, bus.alu_op,
                bus.alu_start, bus.disp_sel, bus.mode, bus.red, bus.blue};
    endfunction

    task automatic r(input logic [9:0] pb, input logic done, input logic [7:0] e,
                     input logic [3:0] wr, input logic [1:0] sa, input logic [1:0] sb,
                     input logic [1:0] op, input logic st, input logic dp,
                     input logic [1:0] md, input logic rd, input logic bl);
        vec_t v;
        v.pb = pb; v.done = done; v.exp = pk(e, wr, sa, sb, op, st, dp, md, rd, bl);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic cyc(input logic [9:0] pb, input logic done);
        bus.pb_pulse = pb;
        bus.alu_done = done;
        @(posedge clk);
        #1;
        bus.pb_pulse = '0;
        bus.alu_done = 1'b0;
    endtask

    initial begin
        bus.pb_pulse = '0;
        bus.alu_done = 1'b0;

        // write path
        r(10'h004, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        for (int i = 0; i < 8; i++)
            r(10'h001, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        r(10'h002, 0, 8'h01, 4'b0000, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        r(10'h040, 0, 8'h01, 4'b0001, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        r(10'h000, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        r(10'h002, 0, 8'h01, 4'b0000, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        r(10'h001, 0, 8'h02, 4'b0000, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        r(10'h080, 0, 8'h02, 4'b0010, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        r(10'h000, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        r(10'h002, 0, 8'h01, 4'b0000, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        r(10'h041, 0, 8'h01, 4'b0000, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        r(10'h010, 0, 8'h01, 4'b0000, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        r(10'h001, 0, 8'h02, 4'b0000, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        r(10'h001, 0, 8'h04, 4'b0000, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        r(10'h001, 0, 8'h08, 4'b0000, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        r(10'h001, 0, 8'h10, 4'b0000, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        r(10'h001, 0, 8'h20, 4'b0000, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        r(10'h001, 0, 8'h40, 4'b0000, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        r(10'h001, 0, 8'h80, 4'b0000, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        r(10'h001, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        // read, add r0+r1, done after a few cycles, re-launch as sub from SHOW
        r(10'h008, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 0, 2'b10, 0, 0);
        r(10'h040, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 0, 2'b10, 0, 0);
        r(10'h080, 0, 8'h00, 4'b0000, 0, 1, 0, 0, 0, 2'b10, 0, 0);
        r(10'h010, 0, 8'h00, 4'b0000, 0, 1, 0, 1, 0, 2'b10, 0, 1);
        for (int i = 0; i < 4; i++)
            r(10'h000, 0, 8'h00, 4'b0000, 0, 1, 0, 0, 0, 2'b10, 0, 1);
        r(10'h000, 1, 8'h00, 4'b0000, 0, 1, 0, 0, 1, 2'b10, 0, 0);
        r(10'h020, 0, 8'h00, 4'b0000, 0, 1, 1, 1, 1, 2'b10, 0, 1);
        r(10'h000, 1, 8'h00, 4'b0000, 0, 1, 1, 0, 1, 2'b10, 0, 0);
        // opcode before B selected
        r(10'h008, 0, 8'h00, 4'b0000, 0, 1, 1, 0, 0, 2'b10, 0, 0);
        r(10'h040, 0, 8'h00, 4'b0000, 0, 1, 1, 0, 0, 2'b10, 0, 0);
        r(10'h020, 0, 8'h00, 4'b0000, 0, 1, 1, 0, 0, 2'b10, 1, 0);
        r(10'h010, 0, 8'h00, 4'b0000, 0, 1, 1, 0, 0, 2'b10, 1, 0);
        r(10'h004, 0, 8'h00, 4'b0000, 0, 1, 1, 0, 0, 2'b01, 0, 0);
        // opcode in RSEL_B, src_b overwrite in RSEL_OP
        r(10'h008, 0, 8'h00, 4'b0000, 0, 1, 1, 0, 0, 2'b10, 0, 0);
        r(10'h100, 0, 8'h00, 4'b0000, 2, 1, 1, 0, 0, 2'b10, 0, 0);
        r(10'h010, 0, 8'h00, 4'b0000, 2, 1, 1, 0, 0, 2'b10, 1, 0);
        r(10'h200, 0, 8'h00, 4'b0000, 2, 3, 1, 0, 0, 2'b10, 1, 0);
        r(10'h100, 0, 8'h00, 4'b0000, 2, 2, 1, 0, 0, 2'b10, 1, 0);
        r(10'h010, 0, 8'h00, 4'b0000, 2, 2, 0, 1, 0, 2'b10, 1, 1);
        r(10'h000, 1, 8'h00, 4'b0000, 2, 2, 0, 0, 1, 2'b10, 1, 0);
        // same register for A and B, launch sub (left running for timeout)
        r(10'h008, 0, 8'h00, 4'b0000, 2, 2, 0, 0, 0, 2'b10, 0, 0);
        r(10'h040, 0, 8'h00, 4'b0000, 0, 2, 0, 0, 0, 2'b10, 0, 0);
        r(10'h040, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 0, 2'b10, 0, 0);
        r(10'h020, 0, 8'h00, 4'b0000, 0, 0, 1, 1, 0, 2'b10, 0, 1);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", obs(), 24'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].pb, vecs[i].done);
            chk($sformatf("vec%0d", i), obs(), vecs[i].exp);
        end

        // timeout: presses during EXEC must not disturb anything
        for (int i = 1; i < 64; i++) begin
            cyc((i % 3 == 0) ? 10'h004 : (i % 3 == 1) ? 10'h008 : 10'h010, 1'b0);
            chk($sformatf("exec_wait%0d", i), obs(),
                pk(8'h00, 4'b0000, 0, 0, 1, 0, 0, 2'b10, 0, 1));
        end
        cyc(10'h000, 1'b0);
        chk("timeout", obs(), pk(8'h00, 4'b0000, 0, 0, 1, 0, 0, 2'b10, 1, 0));

        // done coinciding with the timeout cycle: done wins
        cyc(10'h010, 1'b0);
        chk("relaunch_add", obs(), pk(8'h00, 4'b0000, 0, 0, 0, 1, 0, 2'b10, 1, 1));
        repeat (63) cyc(10'h000, 1'b0);
        chk1("tie_blue_before", bus.blue, 1'b1);
        cyc(10'h000, 1'b1);
        chk("tie_done_wins", obs(), pk(8'h00, 4'b0000, 0, 0, 0, 0, 1, 2'b10, 1, 0));

        // reset mid-EXEC, then a late alu_done
        cyc(10'h020, 1'b0);
        chk1("exec_before_rst", bus.blue, 1'b1);
        cyc(10'h000, 1'b0);
        rst = 1'b1;
        #1;
        chk("async_rst", obs(), 24'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(10'h000, 1'b1);
        chk("late_done_ignored", obs(), 24'h0);
        cyc(10'h004, 1'b0);
        chk("alive_after_rst", obs(), pk(8'h00, 4'b0000, 0, 0, 0, 0, 0, 2'b01, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
